// File: rtl/fixed_decoder_pkg.sv
// Shared FLAC fixed-predictor definitions.
// Holds the maximum fixed predictor order, default sample/accumulator
// widths, field widths for block size and order, and the decoder state
// encoding used by fixed_decoder.
package fixed_decoder_pkg;

    localparam int unsigned MAX_FIXED_ORDER = 4;
    localparam int unsigned SAMPLE_W_DEF    = 16;
    localparam int unsigned ACC_W_DEF       = 21;
    localparam int unsigned ORDER_W         = 4;
    localparam int unsigned BLOCK_W         = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RESIDUAL,
        ST_DONE,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/fixed_predict.sv
// Combinational FLAC fixed predictor.
// Ports:
//   order_i   predictor order (0..4; anything else predicts 0)
//   s1_i..s4_i history samples, s1 newest (signed, SAMPLE_W)
//   p_o       prediction (signed, ACC_W)
module fixed_predict
    import fixed_decoder_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF
) (
    input  logic        [ORDER_W-1:0]  order_i,
    input  logic signed [SAMPLE_W-1:0] s1_i,
    input  logic signed [SAMPLE_W-1:0] s2_i,
    input  logic signed [SAMPLE_W-1:0] s3_i,
    input  logic signed [SAMPLE_W-1:0] s4_i,
    output logic signed [ACC_W-1:0]    p_o
);

    logic signed [ACC_W-1:0] a1, a2, a3, a4;

    // Sign-extend history into the accumulator width before any arithmetic.
    assign a1 = {{(ACC_W-SAMPLE_W){s1_i[SAMPLE_W-1]}}, s1_i};
    assign a2 = {{(ACC_W-SAMPLE_W){s2_i[SAMPLE_W-1]}}, s2_i};
    assign a3 = {{(ACC_W-SAMPLE_W){s3_i[SAMPLE_W-1]}}, s3_i};
    assign a4 = {{(ACC_W-SAMPLE_W){s4_i[SAMPLE_W-1]}}, s4_i};

    // Coefficients built from shifts and adds so all terms stay ACC_W wide.
    always_comb begin
        p_o = '0;
        case (order_i)
            4'd1:    p_o = a1;
            4'd2:    p_o = (a1 <<< 1) - a2;
            4'd3:    p_o = ((a1 <<< 1) + a1) - ((a2 <<< 1) + a2) + a3;
            4'd4:    p_o = (a1 <<< 2) - ((a2 <<< 2) + (a2 <<< 1)) + (a3 <<< 2) - a4;
            default: p_o = '0;
        endcase
    end

endmodule

// File: rtl/fixed_decoder.sv
// FLAC fixed-predictor sample reconstruction.
// Accepts order warm-up samples followed by residuals, reconstructs each
// sample as residual + fixed prediction and emits it one cycle later.
// Ports:
//   iClock, iReset           clock, synchronous active-high reset
//   iEnable                  run when high, freeze all state when low
//   iBlockSize               samples per block (latched in IDLE)
//   iPredictorOrder          fixed order 0..4 (latched in IDLE)
//   iWarmup/iWarmupValid     warm-up sample strobe
//   iResidual/iResidualValid residual strobe
//   oSample/oValid           reconstructed sample and one-cycle strobe
//   oDone                    block complete, held until reset
//   oError                   illegal order, held until reset
module fixed_decoder
    import fixed_decoder_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iEnable,
    input  logic        [BLOCK_W-1:0]  iBlockSize,
    input  logic        [ORDER_W-1:0]  iPredictorOrder,
    input  logic signed [SAMPLE_W-1:0] iWarmup,
    input  logic                       iWarmupValid,
    input  logic signed [SAMPLE_W-1:0] iResidual,
    input  logic                       iResidualValid,
    output logic signed [SAMPLE_W-1:0] oSample,
    output logic                       oValid,
    output logic                       oDone,
    output logic                       oError
);

    state_e                     state_q, state_d;
    logic        [ORDER_W-1:0]  order_q, order_d;
    logic        [BLOCK_W-1:0]  bsize_q, bsize_d;
    logic        [BLOCK_W-1:0]  cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, s4_q, s4_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       valid_q, valid_d;
    logic                       done_q, done_d;
    logic                       error_q, error_d;

    logic signed [ACC_W-1:0]    pred;
    logic signed [ACC_W-1:0]    recon_acc;
    logic signed [SAMPLE_W-1:0] new_sample;
    logic                       take;
    logic        [BLOCK_W-1:0]  cnt_inc;

    fixed_predict #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_predict (
        .order_i (order_q),
        .s1_i    (s1_q),
        .s2_i    (s2_q),
        .s3_i    (s3_q),
        .s4_i    (s4_q),
        .p_o     (pred)
    );

    assign recon_acc = {{(ACC_W-SAMPLE_W){iResidual[SAMPLE_W-1]}}, iResidual} + pred;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        order_d    = order_q;
        bsize_d    = bsize_q;
        cnt_d      = cnt_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        s3_d       = s3_q;
        s4_d       = s4_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        done_d     = done_q;
        error_d    = error_q;
        take       = 1'b0;
        new_sample = '0;

        if (iEnable) begin
            case (state_q)
                ST_IDLE: begin
                    order_d = iPredictorOrder;
                    bsize_d = iBlockSize;
                    cnt_d   = '0;
                    if (iPredictorOrder > ORDER_W'(MAX_FIXED_ORDER)) begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end else if (iBlockSize == '0) begin
                        state_d = ST_DONE;
                    end else if (iPredictorOrder == '0) begin
                        state_d = ST_RESIDUAL;
                    end else begin
                        state_d = ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    take       = iWarmupValid;
                    new_sample = iWarmup;
                end
                ST_RESIDUAL: begin
                    take       = iResidualValid;
                    // Two's-complement wrap: keep only the low sample bits.
                    new_sample = recon_acc[SAMPLE_W-1:0];
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: ;
            endcase

            if (take) begin
                sample_d = new_sample;
                valid_d  = 1'b1;
                s4_d     = s3_q;
                s3_d     = s2_q;
                s2_d     = s1_q;
                s1_d     = new_sample;
                cnt_d    = cnt_inc;
                // Block end wins over the warm-up to residual hand-off.
                if (cnt_inc == bsize_q) begin
                    state_d = ST_DONE;
                end else if (state_q == ST_WARMUP &&
                             cnt_inc == {{(BLOCK_W-ORDER_W){1'b0}}, order_q}) begin
                    state_d = ST_RESIDUAL;
                end
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            order_q  <= '0;
            bsize_q  <= '0;
            cnt_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            s3_q     <= '0;
            s4_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            order_q  <= order_d;
            bsize_q  <= bsize_d;
            cnt_q    <= cnt_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            s4_q     <= s4_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign oSample = sample_q;
    assign oValid  = valid_q;
    assign oDone   = done_q;
    assign oError  = error_q;

endmodule

// File: tb/tb_fixed_decoder.sv
// Self-checking bench for fixed_decoder: directed block scenarios plus
// randomized blocks, checked against a binomial-coefficient reference model.
module tb_fixed_decoder;

    logic               iClock = 1'b0;
    logic               iReset;
    logic               iEnable;
    logic        [15:0] iBlockSize;
    logic        [3:0]  iPredictorOrder;
    logic signed [15:0] iWarmup;
    logic               iWarmupValid;
    logic signed [15:0] iResidual;
    logic               iResidualValid;
    logic signed [15:0] oSample;
    logic               oValid;
    logic               oDone;
    logic               oError;

    always #5 iClock = ~iClock;

    fixed_decoder #(
        .SAMPLE_W (16),
        .ACC_W    (21)
    ) dut (
        .iClock          (iClock),
        .iReset          (iReset),
        .iEnable         (iEnable),
        .iBlockSize      (iBlockSize),
        .iPredictorOrder (iPredictorOrder),
        .iWarmup         (iWarmup),
        .iWarmupValid    (iWarmupValid),
        .iResidual       (iResidual),
        .iResidualValid  (iResidualValid),
        .oSample         (oSample),
        .oValid          (oValid),
        .oDone           (oDone),
        .oError          (oError)
    );

    int checks = 0;
    int errors = 0;
    int wq[$];
    int rq[$];
    int eq[$];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int binom(input int n, input int k);
        int r = 1;
        for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
        return r;
    endfunction

    // Fixed predictor of order n: sum_j (-1)^(j+1) * C(n,j) * s_j.
    function automatic int predict(input int n, input int h[4]);
        int p = 0;
        for (int j = 1; j <= n; j++) begin
            if (j % 2 == 1) p = p + binom(n, j) * h[j-1];
            else            p = p - binom(n, j) * h[j-1];
        end
        return p;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic idle_in();
        iWarmupValid   = 1'b0;
        iResidualValid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sample"}, int'(oSample), 0);
        chk({tag, "_valid"},  int'(oValid),  0);
        chk({tag, "_done"},   int'(oDone),   0);
        chk({tag, "_error"},  int'(oError),  0);
    endtask

    task automatic do_reset(input logic en);
        iEnable = en;
        iReset  = 1'b1;
        idle_in();
        tick();
        iReset = 1'b0;
        chk_zero("reset");
    endtask

    task automatic run_block(input int order, input int bsize, input int max_gap,
                             input int freeze_at, input int abort_after);
        int h[4];
        int expv;
        int v;
        int gap;
        h = '{0, 0, 0, 0};
        iBlockSize      = bsize[15:0];
        iPredictorOrder = order[3:0];
        iEnable         = 1'b1;
        idle_in();
        tick();
        chk("start_valid", int'(oValid), 0);

        if (order > 4) begin
            chk("err_flag", int'(oError), 1);
            for (int i = 0; i < 3; i++) begin
                iWarmupValid   = 1'b1;
                iResidualValid = 1'b1;
                tick();
                chk("err_valid", int'(oValid), 0);
                chk("err_hold",  int'(oError), 1);
            end
            idle_in();
            return;
        end

        for (int k = 0; k < bsize; k++) begin
            if (k == abort_after) begin
                iReset = 1'b1;
                tick();
                iReset = 1'b0;
                chk_zero("abort");
                return;
            end
            if (k == freeze_at) begin
                for (int f = 0; f < 3; f++) begin
                    iEnable        = 1'b0;
                    iResidualValid = (f % 2 == 0);
                    v              = rnd16();
                    iResidual      = v[15:0];
                    tick();
                    chk("freeze_valid", int'(oValid), 0);
                end
                iEnable = 1'b1;
                idle_in();
            end
            gap = int'($urandom_range(max_gap, 0));
            for (int g = 0; g < gap; g++) begin
                // Strobe of the wrong kind must be ignored in each phase.
                v = rnd16();
                if (k < order) begin
                    iResidualValid = 1'b1;
                    iResidual      = v[15:0];
                end else begin
                    iWarmupValid = 1'b1;
                    iWarmup      = v[15:0];
                end
                tick();
                idle_in();
                chk("gap_valid", int'(oValid), 0);
            end
            if (k < order) begin
                v            = (k < wq.size()) ? wq[k] : rnd16();
                iWarmup      = v[15:0];
                iWarmupValid = 1'b1;
                expv         = wrap16(v);
            end else begin
                v              = ((k - order) < rq.size()) ? rq[k-order] : rnd16();
                iResidual      = v[15:0];
                iResidualValid = 1'b1;
                expv           = wrap16(v + predict(order, h));
            end
            tick();
            idle_in();
            chk("out_valid",  int'(oValid),  1);
            chk("out_sample", int'(oSample), expv);
            if (k < eq.size()) chk("table_sample", int'(oSample), eq[k]);
            chk("early_done", int'(oDone), 0);
            h[3] = h[2];
            h[2] = h[1];
            h[1] = h[0];
            h[0] = expv;
        end

        tick();
        chk("done_flag",  int'(oDone),  1);
        chk("done_valid", int'(oValid), 0);
        iWarmupValid   = 1'b1;
        iResidualValid = 1'b1;
        tick();
        idle_in();
        chk("term_valid", int'(oValid), 0);
        chk("term_done",  int'(oDone),  1);
        chk("term_error", int'(oError), 0);
    endtask

    task automatic clear_q();
        wq.delete();
        rq.delete();
        eq.delete();
    endtask

    initial begin
        iReset          = 1'b0;
        iEnable         = 1'b0;
        iBlockSize      = '0;
        iPredictorOrder = '0;
        iWarmup         = '0;
        iResidual       = '0;
        idle_in();

        // Reset with enable low.
        do_reset(1'b0);

        // Order 0 passes residuals through.
        clear_q();
        rq = '{5, -3, 7, 0};
        eq = '{5, -3, 7, 0};
        run_block(0, 4, 0, -1, -1);

        // Order 2 with a warm-up pair.
        do_reset(1'b1);
        clear_q();
        wq = '{10, 12};
        rq = '{1, 0, -1};
        eq = '{10, 12, 15, 18, 20};
        run_block(2, 5, 0, -1, -1);

        // Order 4, back-to-back strobes.
        do_reset(1'b1);
        clear_q();
        wq = '{1, 2, 3, 4};
        rq = '{0, 0};
        eq = '{1, 2, 3, 4, 5, 6};
        run_block(4, 6, 0, -1, -1);

        // Illegal order.
        do_reset(1'b1);
        clear_q();
        run_block(5, 4, 0, -1, -1);

        // Positive overflow wraps.
        do_reset(1'b1);
        clear_q();
        wq = '{32767};
        rq = '{1};
        eq = '{32767, -32768};
        run_block(1, 2, 0, -1, -1);

        // Reset mid-block, then rerun.
        do_reset(1'b1);
        clear_q();
        wq = '{0};
        rq = '{1, 1, 1};
        run_block(1, 4, 0, -1, 2);
        eq = '{0, 1, 2, 3};
        run_block(1, 4, 0, -1, -1);

        // Enable freeze mid-block.
        do_reset(1'b1);
        clear_q();
        run_block(2, 8, 1, 4, -1);

        // Empty block.
        do_reset(1'b1);
        clear_q();
        run_block(3, 0, 0, -1, -1);

        // Block shorter than order ends during warm-up.
        do_reset(1'b1);
        run_block(4, 2, 1, -1, -1);

        // Randomized blocks.
        for (int t = 0; t < 8; t++) begin
            do_reset(1'b1);
            run_block(int'($urandom_range(4, 0)), int'($urandom_range(20, 1)), 2,
                      -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_decoder.md
FIXED_DECODER -- requirements
Module: fixed_decoder

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, reconstructed sample width.
REQ-002 SHALL have parameter ACC_W, default 21, signed prediction accumulator width.
REQ-003 SHALL have port iClock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port iReset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port iEnable  input  1  high = run; low = freeze all state.
REQ-006 SHALL have port iBlockSize  input  16  samples in block, latched at start.
REQ-007 SHALL have port iPredictorOrder  input  4  fixed predictor order, 0..4 legal, latched at start.
REQ-008 SHALL have port iWarmup  input  SAMPLE_W  signed warm-up sample.
REQ-009 SHALL have port iWarmupValid  input  1  iWarmup valid this cycle.
REQ-010 SHALL have port iResidual  input  SAMPLE_W  signed residual from residual decoder.
REQ-011 SHALL have port iResidualValid  input  1  iResidual valid this cycle (residual decoder's oDone strobe).
REQ-012 SHALL have port oSample  output  SAMPLE_W  signed reconstructed sample.
REQ-013 SHALL have port oValid  output  1  one-cycle strobe per oSample.
REQ-014 SHALL have port oDone  output  1  block complete, held until reset.
REQ-015 SHALL have port oError  output  1  illegal order, held until reset.

Function
REQ-016 States SHALL be IDLE, WARMUP, RESIDUAL, DONE, ERROR; all transitions qualified by iEnable=1.
REQ-017 IDLE: latch iBlockSize/iPredictorOrder, clear sample counter; next = ERROR if order>4, RESIDUAL if order=0, else WARMUP.
REQ-018 WARMUP: each iWarmupValid SHALL output iWarmup as oSample next cycle, shift it into history s1..s4 (s1 newest), increment counter; iResidualValid ignored.
REQ-019 WARMUP SHALL exit to RESIDUAL after order warm-ups, or to DONE when counter reaches iBlockSize first.
REQ-020 RESIDUAL: each iResidualValid SHALL output r + P, P = 0 / s1 / 2s1-s2 / 3s1-3s2+s3 / 4s1-6s2+4s3-s4 for order 0..4; iWarmupValid ignored.
REQ-021 Prediction SHALL be computed in ACC_W-bit signed arithmetic; oSample = low SAMPLE_W bits (two's-complement wrap, no saturation).
REQ-022 Each reconstructed sample SHALL be shifted into history in the cycle it is registered to oSample.
REQ-023 Latency SHALL be exactly 1 cycle from input strobe to oValid; back-to-back strobes every cycle SHALL be accepted.
REQ-024 When counter reaches iBlockSize, SHALL enter DONE; oDone asserts the cycle after the last oValid.
REQ-025 DONE and ERROR SHALL be terminal until iReset; strobes ignored, oValid=0.
REQ-026 iEnable=0 SHALL hold state, counter, history; oValid=0; strobes that cycle are dropped.
REQ-027 iBlockSize=0 SHALL go IDLE->DONE with no oValid.

Reset
REQ-028 iReset SHALL force state IDLE, counter 0, history 0, oSample 0, oValid 0, oDone 0, oError 0 on next edge, including mid-block; reset beats iEnable.

Structure
REQ-029 MAX_FIXED_ORDER=4, SAMPLE_W, ACC_W and state encodings SHALL live in the shared FLAC definitions package/include.
REQ-030 Prediction SHALL be a combinational sub-module fixed_predict (inputs order, s1..s4; output P, ACC_W bits); FSM, counter, history in fixed_decoder.

Verification
REQ-031 Order 0, block 4, residuals 5,-3,7,0 -> oSample 5,-3,7,0, then oDone=1.
REQ-032 Order 2, warm-ups 10,12, residuals 1,0,-1, block 5 -> 10,12,15,18,20, then oDone.
REQ-033 Order 4, warm-ups 1,2,3,4, residuals 0,0 back-to-back, block 6 -> 1,2,3,4,5,6 on consecutive cycles.
REQ-034 Order 5 -> oError=1 next cycle, no oValid; order 1 warm-up 32767, residual 1 -> oSample -32768 (wrap).
REQ-035 Order 1 block 4: reset after 2 outputs -> all outputs 0 next cycle; rerun warm-up 0, residuals 1,1,1 -> 0,1,2,3.
REQ-036 iEnable=0 for 3 cycles mid-block with iResidualValid pulsing -> no oValid, history unchanged; resume continues sequence.
